// File: rtl/cpu_pkg.sv
// Shared CPU definitions: shift op encodings, PSR flag bit positions and
// the state encoding of the serial shifter FSM.
package cpu_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sh_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift; bit_out is the bit leaving the word,
// which becomes the new carry.
module shift_step
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] data,
  input  shift_op_t         op,
  output logic [DATA_W-1:0] next_data,
  output logic              bit_out
);

  logic signed [DATA_W-1:0] sdata;
  assign sdata = data;

  always_comb begin
    next_data = data;
    bit_out   = data[0];
    case (op)
      SH_LSL: begin
        next_data = {data[DATA_W-2:0], 1'b0};
        bit_out   = data[DATA_W-1];
      end
      SH_LSR: next_data = {1'b0, data[DATA_W-1:1]};
      SH_ASR: next_data = sdata >>> 1;
      SH_ROR: next_data = {data[0], data[DATA_W-1:1]};
      default: next_data = data;
    endcase
  end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle shifter for the PSR flag path: one bit position per clock,
// then a one-cycle done strobe with the result and {Z,N,C,0} flags.
module serial_shifter
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [DATA_W-1:0]  operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               carry_in,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic [3:0]         flag_out
);

  sh_state_t          state;
  shift_op_t          op_q;
  logic [SHAMT_W-1:0] count;
  logic [DATA_W-1:0]  work;
  logic               carry;
  logic [DATA_W-1:0]  step_data;
  logic               step_bit;

  shift_step #(.DATA_W(DATA_W)) u_step (
    .data      (work),
    .op        (op_q),
    .next_data (step_data),
    .bit_out   (step_bit)
  );

  function automatic logic [3:0] make_flags(input logic [DATA_W-1:0] d, input logic c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (d == '0);
    f[FLAG_N] = d[DATA_W-1];
    f[FLAG_C] = c;
    return f;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      op_q     <= SH_LSL;
      count    <= '0;
      work     <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      flag_out <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            work  <= operand;
            op_q  <= shift_op_t'(op);
            carry <= carry_in;
            count <= shamt;
            if (shamt == '0) begin
              // Zero-length shift completes immediately with the incoming carry.
              state    <= ST_DONE;
              done     <= 1'b1;
              result   <= operand;
              flag_out <= make_flags(operand, carry_in);
            end else begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          work  <= step_data;
          carry <= step_bit;
          count <= count - 1'b1;
          if (count == SHAMT_W'(1)) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= step_data;
            flag_out <= make_flags(step_data, step_bit);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
